// File: rtl/irda_sip_det_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : irda_sip_det_if
//  Description : Signal bundle for the FIR SIP detector. It groups the
//                enable, raw receive line, counter clear and the detector
//                results. clk and reset stay plain ports on the detector.
//                  fast_enable   : FIR mode enable (master -> slave)
//                  rx_i          : raw IR receive line (master -> slave)
//                  sip_cnt_clr_i : synchronous counter clear (master -> slave)
//                  sip_det_o     : one-cycle valid-SIP pulse (slave -> master)
//                  sip_err_o     : one-cycle rejected-pulse flag (slave -> master)
//                  sip_cnt_o     : saturating SIP count (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface irda_sip_det_if;
    logic       fast_enable;
    logic       rx_i;
    logic       sip_cnt_clr_i;
    logic       sip_det_o;
    logic       sip_err_o;
    logic [7:0] sip_cnt_o;

    modport master (
        output fast_enable,
        output rx_i,
        output sip_cnt_clr_i,
        input  sip_det_o,
        input  sip_err_o,
        input  sip_cnt_o
    );

    modport slave (
        input  fast_enable,
        input  rx_i,
        input  sip_cnt_clr_i,
        output sip_det_o,
        output sip_err_o,
        output sip_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/irda_sip_det.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : irda_sip_det
//  Description : Receive-side Serial Infrared Interaction Pulse detector for
//                the FIR path. Synchronises the raw IR line, measures each
//                high pulse and the low gap after it, and flags a SIP when
//                both fall inside the programmed windows. Keeps a saturating
//                8-bit count of detected SIPs.
//  Ports       : clk       - system clock
//                wb_rst_i  - asynchronous active-high reset
//                bus       - irda_sip_det_if.slave (enable, rx line, counter
//                            clear in; det/err pulses and count out)
//  Revision    : 1.0 - initial release
// ============================================================================
module irda_sip_det #(
    parameter int CW   = 9,
    parameter int HMIN = 48,
    parameter int HMAX = 80,
    parameter int LMIN = 256
) (
    input  logic           clk,
    input  logic           wb_rst_i,
    irda_sip_det_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HIGH    = 3'd1,
        ST_LOW     = 3'd2,
        ST_TOOLONG = 3'd3
    } state_t;

    localparam logic [CW-1:0] C_ONE     = CW'(1);
    localparam logic [CW-1:0] C_HMIN    = CW'(HMIN);
    localparam logic [CW-1:0] C_HMAX    = CW'(HMAX);
    localparam logic [CW-1:0] C_LMIN_M1 = CW'(LMIN - 1);

    // Synchronizer, edge-detect delay and the validity pipeline beside them
    logic sync1_q, sync1_d;
    logic rx_s_q,  rx_s_d;
    logic rx_d_q,  rx_d_d;
    logic vld1_q,  vld1_d;
    logic vld2_q,  vld2_d;
    logic armed_q, armed_d;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          det_q,   det_d;
    logic          err_q,   err_d;
    logic [7:0]    sip_cnt_q, sip_cnt_d;

    logic rise;

    // The synchronizer flops come out of reset at 0, so a line that is
    // already high would look like a fresh rising edge. armed only sets once
    // a genuine low sample has reached rx_s (vld2 marks rx_s as holding a
    // real post-reset sample), which keeps such a line ignored until it
    // falls and rises again.
    assign rise = rx_s_q & ~rx_d_q & armed_q;

    always_comb begin
        sync1_d   = bus.rx_i;
        rx_s_d    = sync1_q;
        rx_d_d    = rx_s_q;
        vld1_d    = 1'b1;
        vld2_d    = vld1_q;
        armed_d   = armed_q | (vld2_q & ~rx_s_q);

        state_d   = state_q;
        cnt_d     = cnt_q;
        det_d     = 1'b0;
        err_d     = 1'b0;
        sip_cnt_d = sip_cnt_q;

        if (!bus.fast_enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (rise) begin
                        state_d = ST_HIGH;
                        cnt_d   = C_ONE;
                    end
                end
                ST_HIGH: begin
                    if (rx_s_q) begin
                        if (cnt_q == C_HMAX) begin
                            state_d = ST_TOOLONG;
                            err_d   = 1'b1;
                        end else begin
                            cnt_d = cnt_q + C_ONE;
                        end
                    end else if ((cnt_q >= C_HMIN) && (cnt_q <= C_HMAX)) begin
                        // First low sample already counts towards the gap
                        state_d = ST_LOW;
                        cnt_d   = C_ONE;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        err_d   = 1'b1;
                    end
                end
                ST_LOW: begin
                    if (rx_s_q) begin
                        // Gap cut short: reject the old pulse, measure the new one
                        state_d = ST_HIGH;
                        cnt_d   = C_ONE;
                        err_d   = 1'b1;
                    end else if (cnt_q == C_LMIN_M1) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        det_d   = 1'b1;
                        if (sip_cnt_q != 8'hFF) begin
                            sip_cnt_d = sip_cnt_q + 8'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + C_ONE;
                    end
                end
                ST_TOOLONG: begin
                    if (!rx_s_q) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // Clear takes precedence over an increment in the same cycle
        if (bus.sip_cnt_clr_i) begin
            sip_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sync1_q   <= 1'b0;
            rx_s_q    <= 1'b0;
            rx_d_q    <= 1'b0;
            vld1_q    <= 1'b0;
            vld2_q    <= 1'b0;
            armed_q   <= 1'b0;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            det_q     <= 1'b0;
            err_q     <= 1'b0;
            sip_cnt_q <= '0;
        end else begin
            sync1_q   <= sync1_d;
            rx_s_q    <= rx_s_d;
            rx_d_q    <= rx_d_d;
            vld1_q    <= vld1_d;
            vld2_q    <= vld2_d;
            armed_q   <= armed_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            det_q     <= det_d;
            err_q     <= err_d;
            sip_cnt_q <= sip_cnt_d;
        end
    end

    assign bus.sip_det_o = det_q;
    assign bus.sip_err_o = err_q;
    assign bus.sip_cnt_o = sip_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_irda_sip_det.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_irda_sip_det
//  Description : Self-checking bench for irda_sip_det. A run-length model of
//                the detection rules predicts det/err/count every cycle for
//                the default-parameter instance; hand-computed literals pin
//                the timing. A second, small-window instance reaches counter
//                saturation quickly.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_irda_sip_det;

    localparam int HMIN = 48;
    localparam int HMAX = 80;
    localparam int LMIN = 256;

    logic clk = 1'b0;
    logic wb_rst_i;
    logic rst_s;
    always #5 clk = ~clk;

    irda_sip_det_if bus ();
    irda_sip_det_if bus_s ();

    irda_sip_det u_dut (
        .clk      (clk),
        .wb_rst_i (wb_rst_i),
        .bus      (bus)
    );

    irda_sip_det #(.CW(5), .HMIN(4), .HMAX(8), .LMIN(16)) u_dut_s (
        .clk      (clk),
        .wb_rst_i (rst_s),
        .bus      (bus_s)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: works on run lengths of the 2-edge-delayed receive samples.
    // ------------------------------------------------------------------
    bit hist[$];
    bit armed, counted, gap;
    int hi_run, lo_run;
    bit m_det, m_err;
    int m_cnt;

    always @(posedge clk) begin
        bit s, sp, s_valid;
        cyc++;
        m_det = 1'b0;
        m_err = 1'b0;
        if (wb_rst_i) begin
            hist.delete();
            armed = 0; counted = 0; gap = 0;
            hi_run = 0; lo_run = 0; m_cnt = 0;
        end else begin
            s = 0; sp = 0; s_valid = 0;
            if (hist.size() >= 2) begin
                s_valid = 1;
                s  = hist[hist.size()-2];
                sp = (hist.size() >= 3) ? hist[hist.size()-3] : 1'b0;
            end
            if (!bus.fast_enable) begin
                counted = 0; gap = 0;
            end else if (s) begin
                if (!sp && armed) begin
                    if (gap) m_err = 1;
                    gap = 0; counted = 1; hi_run = 1;
                end else if (counted) begin
                    hi_run++;
                    if (hi_run == HMAX + 1) begin
                        m_err = 1; counted = 0;
                    end
                end
            end else begin
                if (counted) begin
                    counted = 0;
                    if (hi_run >= HMIN && hi_run <= HMAX) begin
                        gap = 1; lo_run = 1;
                    end else begin
                        m_err = 1;
                    end
                end else if (gap) begin
                    lo_run++;
                    if (lo_run == LMIN) begin
                        m_det = 1; gap = 0;
                    end
                end
            end
            if (s_valid && !s) armed = 1;
            hist.push_back(bus.rx_i);
            if (hist.size() > 3) void'(hist.pop_front());
            if (bus.sip_cnt_clr_i)              m_cnt = 0;
            else if (m_det && m_cnt != 255)     m_cnt = m_cnt + 1;
        end
    end

    // ------------------------------------------------------------------
    // Compare process: every cycle, just after the active edge.
    // ------------------------------------------------------------------
    int det_total = 0, err_total = 0;
    int last_det_cyc = -1, last_err_cyc = -1;

    always @(posedge clk) begin
        #1;
        check("det_vs_model", int'(bus.sip_det_o), int'(m_det));
        check("err_vs_model", int'(bus.sip_err_o), int'(m_err));
        check("cnt_vs_model", int'(bus.sip_cnt_o), m_cnt);
        if (bus.sip_det_o && bus.sip_err_o)
            check("det_err_exclusive", 1, 0);
        if (bus.sip_det_o) begin det_total++; last_det_cyc = cyc; end
        if (bus.sip_err_o) begin err_total++; last_err_cyc = cyc; end
    end

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Main directed sequence (default parameters)
    // ------------------------------------------------------------------
    bit small_done = 0;

    initial begin
        int e1, d0, r0;
        wb_rst_i = 1'b1;
        bus.fast_enable = 1'b1;
        bus.rx_i = 1'b0;
        bus.sip_cnt_clr_i = 1'b0;
        hold(4);
        check("reset_det", int'(bus.sip_det_o), 0);
        check("reset_err", int'(bus.sip_err_o), 0);
        check("reset_cnt", int'(bus.sip_cnt_o), 0);
        wb_rst_i = 1'b0;
        hold(10);

        // Generator-nominal pulse
        d0 = det_total; r0 = err_total;
        bus.rx_i = 1'b1; hold(64);
        bus.rx_i = 1'b0; e1 = cyc + 1; hold(400);
        check("nominal_det_edge", last_det_cyc - e1 + 1, 258);
        check("nominal_det_count", det_total - d0, 1);
        check("nominal_err_count", err_total - r0, 0);
        check("nominal_cnt", int'(bus.sip_cnt_o), 1);

        // Too short: error on the falling-edge evaluation
        d0 = det_total; r0 = err_total;
        bus.rx_i = 1'b1; hold(47);
        bus.rx_i = 1'b0; e1 = cyc + 1; hold(300);
        check("short47_err_edge", last_err_cyc - e1 + 1, 3);
        check("short47_err_count", err_total - r0, 1);
        check("short47_det_count", det_total - d0, 0);

        // Boundary widths accepted
        d0 = det_total;
        bus.rx_i = 1'b1; hold(48);
        bus.rx_i = 1'b0; hold(300);
        bus.rx_i = 1'b1; hold(80);
        bus.rx_i = 1'b0; hold(300);
        check("w48_w80_det_count", det_total - d0, 2);
        check("w48_w80_cnt", int'(bus.sip_cnt_o), 3);

        // Too long: error at edge HMAX+3, no error when the line falls
        d0 = det_total; r0 = err_total;
        bus.rx_i = 1'b1; e1 = cyc + 1; hold(81);
        bus.rx_i = 1'b0; hold(300);
        check("long81_err_edge", last_err_cyc - e1 + 1, 83);
        check("long81_err_count", err_total - r0, 1);
        check("long81_det_count", det_total - d0, 0);

        // Gap interrupted by a second pulse
        d0 = det_total; r0 = err_total;
        bus.rx_i = 1'b1; hold(64);
        bus.rx_i = 1'b0; hold(200);
        bus.rx_i = 1'b1; e1 = cyc + 1; hold(64);
        bus.rx_i = 1'b0; hold(300);
        check("gap_err_edge", last_err_cyc - e1 + 1, 3);
        check("gap_err_count", err_total - r0, 1);
        check("gap_det_count", det_total - d0, 1);
        check("gap_cnt", int'(bus.sip_cnt_o), 4);

        // Enable dropped during the gap
        d0 = det_total; r0 = err_total;
        bus.rx_i = 1'b1; hold(64);
        bus.rx_i = 1'b0; hold(99);
        bus.fast_enable = 1'b0; hold(10);
        bus.fast_enable = 1'b1; hold(400);
        check("enable_det_count", det_total - d0, 0);
        check("enable_err_count", err_total - r0, 0);
        check("enable_cnt_hold", int'(bus.sip_cnt_o), 4);

        // Reset in the middle of a high pulse
        d0 = det_total; r0 = err_total;
        bus.rx_i = 1'b1; hold(30);
        wb_rst_i = 1'b1; hold(3);
        check("midrst_cnt", int'(bus.sip_cnt_o), 0);
        check("midrst_det", int'(bus.sip_det_o), 0);
        wb_rst_i = 1'b0; hold(50);
        bus.rx_i = 1'b0; hold(400);
        check("midrst_det_count", det_total - d0, 0);
        check("midrst_err_count", err_total - r0, 0);

        // Line high straight out of reset
        bus.rx_i = 1'b1;
        wb_rst_i = 1'b1; hold(3);
        wb_rst_i = 1'b0; hold(100);
        bus.rx_i = 1'b0; hold(400);
        check("highstart_det_count", det_total - d0, 0);
        check("highstart_err_count", err_total - r0, 0);

        // One SIP, then clear coinciding with the next detection
        bus.rx_i = 1'b1; hold(64);
        bus.rx_i = 1'b0; hold(300);
        check("pre_clear_cnt", int'(bus.sip_cnt_o), 1);
        bus.rx_i = 1'b1; hold(64);
        bus.rx_i = 1'b0; e1 = cyc + 1; hold(257);
        bus.sip_cnt_clr_i = 1'b1; hold(1);
        bus.sip_cnt_clr_i = 1'b0;
        check("clrdet_det_edge", last_det_cyc - e1 + 1, 258);
        check("clrdet_cnt", int'(bus.sip_cnt_o), 0);
        hold(50);

        while (!small_done) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // ------------------------------------------------------------------
    // Small-window instance: saturation of the SIP counter
    // ------------------------------------------------------------------
    initial begin
        rst_s = 1'b1;
        bus_s.fast_enable = 1'b1;
        bus_s.rx_i = 1'b0;
        bus_s.sip_cnt_clr_i = 1'b0;
        hold(4);
        rst_s = 1'b0;
        hold(5);
        for (int i = 1; i <= 256; i++) begin
            bus_s.rx_i = 1'b1; hold(6);
            bus_s.rx_i = 1'b0; hold(20);
            if (i == 1)   check("sat_cnt_1", int'(bus_s.sip_cnt_o), 1);
            if (i == 100) check("sat_cnt_100", int'(bus_s.sip_cnt_o), 100);
            if (i == 255) check("sat_cnt_255", int'(bus_s.sip_cnt_o), 255);
            if (i == 256) check("sat_cnt_256", int'(bus_s.sip_cnt_o), 255);
        end
        bus_s.sip_cnt_clr_i = 1'b1; hold(1);
        bus_s.sip_cnt_clr_i = 1'b0;
        check("sat_clear", int'(bus_s.sip_cnt_o), 0);
        small_done = 1'b1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, cycle=%0d required<30000", cyc);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/irda_sip_det.md
# irda_sip_det

Receive-side Serial Infrared Interaction Pulse (SIP) detector for the FIR (4 Mb/s) path. It monitors the raw IR receive line and measures the width of each high pulse and the low gap that follows. It flags a valid SIP when both fall inside programmed windows, and keeps a saturating count of detected SIPs. It is the receiving counterpart of the SIP generator and shares its clock. With default parameters it accepts the generator's nominal 64-cycle high / 284-cycle low pattern.

## Interface
Parameters:
- CW, 9, width of the internal width counter; must hold max(HMAX, LMIN).
- HMIN, 48, minimum accepted high-pulse width, in clk samples.
- HMAX, 80, maximum accepted high-pulse width, in clk samples.
- LMIN, 256, number of consecutive low samples after the pulse required for detection.

Ports:
- clk  in  1  system clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- fast_enable  in  1  FIR mode enable; when low the detector is held idle.
- rx_i  in  1  raw IR receive line, asynchronous to clk, active-high pulse.
- sip_cnt_clr_i  in  1  synchronous clear of sip_cnt_o.
- sip_det_o  out  1  one-cycle pulse: valid SIP detected.
- sip_err_o  out  1  one-cycle pulse: candidate pulse rejected.
- sip_cnt_o  out  8  saturating count of detected SIPs.

## Operation
- rx_i passes through a 2-flop synchronizer to give rx_s. A third flop gives rx_d. A rising edge is rx_s & ~rx_d.
- Counter cnt (CW bits). On evaluation of the k-th consecutive sample at a level, cnt = k-1.
- States and transitions:
  - IDLE: on a rising edge, go to HIGH with cnt=1. A line already high on entry is ignored until it next rises.
  - HIGH, rx_s=1: if cnt==HMAX, go to TOOLONG and pulse err. Otherwise increment cnt.
  - HIGH, rx_s=0: width W=cnt. If HMIN<=W<=HMAX, go to LOW with cnt=1. Otherwise go to IDLE and pulse err.
  - LOW, rx_s=1: pulse err, go to HIGH with cnt=1. The interrupting pulse becomes the new candidate.
  - LOW, rx_s=0: if cnt==LMIN-1, pulse det, increment sip_cnt (saturate at 255), go to IDLE. Otherwise increment cnt.
  - TOOLONG: when rx_s=0, go to IDLE. No err pulse on exit.
  - Illegal state encodings: go to IDLE.
- fast_enable=0 has priority over all state logic:
  - state forced to IDLE, cnt=0, sip_det_o=0, sip_err_o=0;
  - sip_cnt_o holds its value;
  - the synchronizer keeps running.
- sip_cnt_clr_i: sip_cnt_o=0 next cycle. Clear wins over a simultaneous increment.
- Reset values:
  - state IDLE;
  - cnt 0;
  - synchronizer flops and rx_d 0;
  - sip_det_o 0, sip_err_o 0, sip_cnt_o 0.
- Reset mid-pulse: detector returns to IDLE. A line still high after reset is not treated as a pulse until a new rising edge.

## Timing
- All outputs are registered.
- Synchronizer latency is 2 clk. rx_s reflects rx_i as sampled 2 edges earlier.
- Numbering edges from 1, where edge 1 is the first edge that samples rx_i high:
  - rx_s is high after edge 2;
  - HIGH is entered at edge 3.
- A high level present for exactly W sampling edges gives measured width W. Accepted iff HMIN<=W<=HMAX.
- Detection: sip_det_o is high for exactly one cycle, starting at edge LMIN+2. Edge 1 here is the first edge that samples rx_i low.
- Too-long rejection: sip_err_o is asserted at edge HMAX+3, counting from the first edge that samples rx_i high.
- sip_det_o and sip_err_o are never high in the same cycle.
- After a detection, the detector can accept a new rising edge on the very next evaluation cycle.

## Test plan
- Generator-nominal pulse (defaults): rx_i high 64 clk, then low 400 clk -> one sip_det_o pulse at edge 258 after the falling sample, sip_err_o never asserted, sip_cnt_o=1.
- Width bounds: high 47 -> sip_err_o on the falling-edge evaluation, no det. High 48 and high 80 -> det. High 81 -> sip_err_o at edge 83, state TOOLONG, no det, then IDLE after the line falls.
- Gap interrupt: high 64, low 200, high 64, low 300 -> one sip_err_o at the second rise, exactly one sip_det_o (for the second pulse), sip_cnt_o=1.
- Enable/reset mid-operation: fast_enable dropped at low sample 100, then restored -> no det, no err, cnt reset. wb_rst_i asserted during a high pulse -> all outputs 0, remainder of that pulse ignored.
- Counter: 256 valid SIPs -> sip_cnt_o saturates at 255. sip_cnt_clr_i in the same cycle as a detection -> sip_cnt_o=0 next cycle.
- Line high at start: rx_i high out of reset for 100 clk, then low 400 -> no det, no err.
